// File: rtl/tm1638_refresh_seq.sv
// -----------------------------------------------------------------------------
// tm1638_refresh_seq
//
// Command sequencer that sits upstream of the TM1638 byte writer. A refresh
// request snapshots the display image, then sends the complete TM1638 write
// protocol as three STB-low windows:
//   frame 0 : 0x40                               (data write, auto-increment)
//   frame 1 : 0xC0|START_ADDR, data[0..NUM_BYTES-1]
//   frame 2 : 0x80 | display_on<<3 | brightness  (display control)
// This block owns STB. CLK/DIO belong to the byte writer.
//
// Ports
//   drvclk      in   driver clock, all logic on the rising edge
//   reset_n     in   synchronous active-low reset
//   refresh     in   refresh request, level or pulse, sampled every cycle
//   seg_data    in   display image, byte i -> address START_ADDR+i
//   brightness  in   PWM level for the display-control command
//   display_on  in   display enable for the display-control command
//   busy        out  high from request acceptance until DONE
//   done        out  one-cycle pulse after frame 2 STB has returned high
//   wb_start    out  one-cycle start strobe to the byte writer
//   wb_data     out  byte for the writer
//   wb_busy     in   byte writer busy
//   dev_stb     out  TM1638 STB, active low
//
// Writer handshake: wb_start is a single-cycle strobe that carries wb_data.
// The writer raises wb_busy the cycle after the strobe and drops it when the
// byte has been shifted out. wb_data is held from the strobe until wb_busy
// falls. A new strobe is only issued after wb_busy has been seen high and then
// low again, so a late-rising busy is never mistaken for completion.
//
// All outputs are registered and decoded from the next state, so each one is
// exactly a function of the current state and is glitch-free at the pins.
// -----------------------------------------------------------------------------
module tm1638_refresh_seq #(
    parameter int NUM_BYTES  = 16,
    parameter int START_ADDR = 0,
    parameter int STB_GAP    = 2
) (
    input  logic                   drvclk,
    input  logic                   reset_n,
    input  logic                   refresh,
    input  logic [8*NUM_BYTES-1:0] seg_data,
    input  logic [2:0]             brightness,
    input  logic                   display_on,
    output logic                   busy,
    output logic                   done,
    output logic                   wb_start,
    output logic [7:0]             wb_data,
    input  logic                   wb_busy,
    output logic                   dev_stb
);

    localparam int IDX_W = 5;
    localparam int GAP_W = $clog2(STB_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STB_LO = 3'd1,
        S_ISSUE  = 3'd2,
        S_ACK    = 3'd3,
        S_DRAIN  = 3'd4,
        S_STB_HI = 3'd5,
        S_GAP    = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             frame_q, frame_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   pending_q, pending_d;
    logic [8*NUM_BYTES-1:0] snap_seg_q, snap_seg_d;
    logic [2:0]             snap_bri_q, snap_bri_d;
    logic                   snap_on_q, snap_on_d;

    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   wb_start_q, wb_start_d;
    logic [7:0]             wb_data_q, wb_data_d;
    logic                   dev_stb_q, dev_stb_d;

    logic [7:0]             next_byte;

    // Byte for the (frame, idx) being entered. In frame 1, idx 0 is the
    // address command and idx k>0 is data byte k-1.
    always_comb begin
        next_byte = 8'h40;
        case (frame_d)
            2'd1: begin
                if (idx_d == '0) begin
                    next_byte = 8'hC0 | 8'(START_ADDR);
                end else begin
                    next_byte = 8'h00;
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (idx_d == IDX_W'(i + 1)) begin
                            next_byte = snap_seg_q[8*i +: 8];
                        end
                    end
                end
            end
            2'd2:    next_byte = {4'b1000, snap_on_q, snap_bri_q};
            default: next_byte = 8'h40;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        // Any request outside IDLE folds into a single pending refresh.
        pending_d  = pending_q | (refresh & (state_q != S_IDLE));
        snap_seg_d = snap_seg_q;
        snap_bri_d = snap_bri_q;
        snap_on_d  = snap_on_q;

        case (state_q)
            S_IDLE: begin
                if (refresh || pending_q) begin
                    snap_seg_d = seg_data;
                    snap_bri_d = brightness;
                    snap_on_d  = display_on;
                    pending_d  = 1'b0;
                    frame_d    = 2'd0;
                    idx_d      = '0;
                    state_d    = S_STB_LO;
                end
            end
            S_STB_LO: state_d = S_ISSUE;
            S_ISSUE:  state_d = S_ACK;
            S_ACK: begin
                if (wb_busy) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!wb_busy) begin
                    if (frame_q == 2'd1 && idx_q != IDX_W'(NUM_BYTES)) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_STB_HI;
                    end
                end
            end
            S_STB_HI: begin
                gap_d   = GAP_W'(STB_GAP - 1);
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    if (frame_q != 2'd2) begin
                        frame_d = frame_q + 1'b1;
                        idx_d   = '0;
                        state_d = S_STB_LO;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // STB stays low through STB_HI; it rises as GAP is entered, so it is
        // high for exactly STB_GAP cycles between frames.
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        wb_start_d = (state_d == S_ISSUE);
        dev_stb_d  = !((state_d == S_STB_LO) || (state_d == S_ISSUE) ||
                       (state_d == S_ACK)    || (state_d == S_DRAIN) ||
                       (state_d == S_STB_HI));
        wb_data_d  = (state_d == S_ISSUE) ? next_byte : wb_data_q;
    end

    always_ff @(posedge drvclk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            frame_q    <= 2'd0;
            idx_q      <= '0;
            gap_q      <= '0;
            pending_q  <= 1'b0;
            snap_seg_q <= '0;
            snap_bri_q <= 3'd0;
            snap_on_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wb_start_q <= 1'b0;
            wb_data_q  <= 8'h00;
            dev_stb_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            pending_q  <= pending_d;
            snap_seg_q <= snap_seg_d;
            snap_bri_q <= snap_bri_d;
            snap_on_q  <= snap_on_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wb_start_q <= wb_start_d;
            wb_data_q  <= wb_data_d;
            dev_stb_q  <= dev_stb_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wb_start = wb_start_q;
    assign wb_data  = wb_data_q;
    assign dev_stb  = dev_stb_q;

endmodule

// File: tb/tb_tm1638_refresh_seq.sv
// -----------------------------------------------------------------------------
// Bench for tm1638_refresh_seq. Two instances share clock and reset:
//   a : NUM_BYTES=16, START_ADDR=0, STB_GAP=2
//   b : NUM_BYTES=1,  START_ADDR=5, STB_GAP=4
// Each has a byte-writer model (busy rises the cycle after start, high for 17
// cycles). Expected bytes are queued as {first_in_stb_window, byte} when a
// refresh is requested and popped as the DUT strobes wb_start.
// -----------------------------------------------------------------------------
module tb_tm1638_refresh_seq;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;

  logic         refresh_a = 1'b0;
  logic [127:0] seg_a = '0;
  logic [2:0]   bri_a = 3'd0;
  logic         on_a = 1'b0;
  logic         busy_a, done_a, start_a, stb_a;
  logic [7:0]   data_a;
  logic         wbbusy_a = 1'b0;
  int           wcnt_a = 0;

  logic         refresh_b = 1'b0;
  logic [7:0]   seg_b = '0;
  logic [2:0]   bri_b = 3'd0;
  logic         on_b = 1'b0;
  logic         busy_b, done_b, start_b, stb_b;
  logic [7:0]   data_b;
  logic         wbbusy_b = 1'b0;
  int           wcnt_b = 0;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_a_q[$];
  logic [8:0] exp_b_q[$];

  always #5 clk = ~clk;

  tm1638_refresh_seq #(.NUM_BYTES(16), .START_ADDR(0), .STB_GAP(2)) u_dut_a (
    .drvclk(clk), .reset_n(reset_n), .refresh(refresh_a), .seg_data(seg_a),
    .brightness(bri_a), .display_on(on_a), .busy(busy_a), .done(done_a),
    .wb_start(start_a), .wb_data(data_a), .wb_busy(wbbusy_a), .dev_stb(stb_a)
  );

  tm1638_refresh_seq #(.NUM_BYTES(1), .START_ADDR(5), .STB_GAP(4)) u_dut_b (
    .drvclk(clk), .reset_n(reset_n), .refresh(refresh_b), .seg_data(seg_b),
    .brightness(bri_b), .display_on(on_b), .busy(busy_b), .done(done_b),
    .wb_start(start_b), .wb_data(data_b), .wb_busy(wbbusy_b), .dev_stb(stb_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // byte writer models
  always @(posedge clk) begin
    if (!reset_n) begin
      wbbusy_a <= 1'b0; wcnt_a <= 0;
    end else if (start_a) begin
      wbbusy_a <= 1'b1; wcnt_a <= 16;
    end else if (wcnt_a != 0) begin
      wcnt_a <= wcnt_a - 1;
    end else begin
      wbbusy_a <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      wbbusy_b <= 1'b0; wcnt_b <= 0;
    end else if (start_b) begin
      wbbusy_b <= 1'b1; wcnt_b <= 16;
    end else if (wcnt_b != 0) begin
      wcnt_b <= wcnt_b - 1;
    end else begin
      wbbusy_b <= 1'b0;
    end
  end

  // monitors / scoreboard
  logic       newwin_a = 1'b1, prev_stb_a = 1'b1;
  logic [7:0] held_a = '0;
  int         done_cnt_a = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (start_a) begin
      check("a_stb_low_at_start", stb_a, 0);
      check("a_queue_has_entry", exp_a_q.size() != 0, 1);
      if (exp_a_q.size() != 0) begin
        e = exp_a_q.pop_front();
        check("a_byte", {newwin_a, data_a}, e);
      end
      newwin_a = 1'b0;
      held_a = data_a;
    end else if (wbbusy_a) begin
      check("a_data_stable", data_a, held_a);
    end
    if (done_a) done_cnt_a++;
    if (stb_a === 1'b1 && prev_stb_a === 1'b0) newwin_a = 1'b1;
    prev_stb_a = stb_a;
  end

  logic newwin_b = 1'b1, prev_stb_b = 1'b1;
  int   done_cnt_b = 0;
  int   run_b = 0;
  int   win_b = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (start_b) begin
      check("b_stb_low_at_start", stb_b, 0);
      check("b_queue_has_entry", exp_b_q.size() != 0, 1);
      if (exp_b_q.size() != 0) begin
        e = exp_b_q.pop_front();
        check("b_byte", {newwin_b, data_b}, e);
      end
      newwin_b = 1'b0;
    end
    if (stb_b === 1'b1) begin
      run_b++;
    end else if (prev_stb_b === 1'b1) begin
      if (win_b > 0) check("b_stb_gap_len", run_b, 4);
      win_b++;
      run_b = 0;
    end
    if (done_b) begin
      done_cnt_b++;
      win_b = 0;
    end
    if (stb_b === 1'b1 && prev_stb_b === 1'b0) newwin_b = 1'b1;
    prev_stb_b = stb_b;
  end

  // expected byte streams
  task automatic push_a(input logic [127:0] seg, input logic [2:0] bri, input logic on);
    exp_a_q.push_back({1'b1, 8'h40});
    exp_a_q.push_back({1'b1, 8'hC0});
    for (int i = 0; i < 16; i++) exp_a_q.push_back({1'b0, seg[8*i +: 8]});
    exp_a_q.push_back({1'b1, 8'h80 | ({7'd0, on} << 3) | {5'd0, bri}});
  endtask

  task automatic push_b();
    exp_b_q.push_back({1'b1, 8'h40});
    exp_b_q.push_back({1'b1, 8'hC5});
    exp_b_q.push_back({1'b0, seg_b});
    exp_b_q.push_back({1'b1, 8'h80 | ({7'd0, on_b} << 3) | {5'd0, bri_b}});
  endtask

  task automatic pulse_a();
    @(negedge clk) refresh_a = 1'b1;
    @(negedge clk) refresh_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int bound);
    int n = 0;
    while (done_a !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, done_a, 1);
  endtask

  task automatic wait_cnt(input int which, input int target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (which == 0 && done_cnt_a >= target) break;
      if (which == 1 && done_cnt_b >= target) break;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [127:0] pat;
    int base;

    // clock/reset
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_stb", stb_a, 1);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_done", done_a, 0);
    check("rst_a_start", start_a, 0);
    check("rst_a_data", data_a, 8'h00);
    check("rst_b_stb", stb_b, 1);
    check("rst_b_busy", busy_b, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1+2) full refresh with snapshot honoured
    for (int i = 0; i < 16; i++) pat[8*i +: 8] = 8'(i);
    seg_a = pat; bri_a = 3'd7; on_a = 1'b1;
    push_a(pat, 3'd7, 1'b1);
    base = done_cnt_a;
    pulse_a();
    check("t1_busy_after_accept", busy_a, 1);
    seg_a = {16{8'hFF}}; bri_a = 3'd0; on_a = 1'b0;
    wait_done_a("t1_done_seen", 2000);
    @(negedge clk);
    check("t1_busy_after_done", busy_a, 0);
    repeat (50) @(negedge clk);
    check("t1_single_done", done_cnt_a - base, 1);
    check("t1_queue_empty", exp_a_q.size(), 0);

    // 3) three requests during frame 1 collapse into one pending refresh
    for (int i = 0; i < 16; i++) pat[8*i +: 8] = 8'($urandom_range(0, 255));
    seg_a = pat; bri_a = 3'd2; on_a = 1'b1;
    push_a(pat, 3'd2, 1'b1);
    push_a(pat, 3'd2, 1'b1);
    base = done_cnt_a;
    pulse_a();
    repeat (60) @(negedge clk);
    check("t3_in_frame1_stb", stb_a, 0);
    pulse_a();
    repeat (10) @(negedge clk);
    pulse_a();
    repeat (10) @(negedge clk);
    pulse_a();
    wait_done_a("t3_first_done", 2000);
    @(negedge clk);
    check("t3_idle_cycle_busy", busy_a, 0);
    @(negedge clk);
    check("t3_restart_busy", busy_a, 1);
    wait_cnt(0, base + 2, 2000);
    repeat (200) @(negedge clk);
    check("t3_two_refreshes", done_cnt_a - base, 2);
    check("t3_busy_idle", busy_a, 0);
    check("t3_queue_empty", exp_a_q.size(), 0);

    // 6) reset in the middle of data byte 7
    for (int i = 0; i < 16; i++) pat[8*i +: 8] = 8'(8'h10 + i);
    seg_a = pat; bri_a = 3'd5; on_a = 1'b1;
    push_a(pat, 3'd5, 1'b1);
    base = done_cnt_a;
    pulse_a();
    begin
      int n = 0;
      while (!(start_a === 1'b1 && data_a === 8'h17) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("t6_byte7_started", data_a, 8'h17);
    end
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    exp_a_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    check("t6_stb_high", stb_a, 1);
    check("t6_busy_low", busy_a, 0);
    check("t6_start_low", start_a, 0);
    repeat (100) @(negedge clk);
    check("t6_no_done", done_cnt_a - base, 0);
    check("t6_still_idle", busy_a, 0);
    for (int i = 0; i < 16; i++) pat[8*i +: 8] = 8'($urandom_range(0, 255));
    seg_a = pat; bri_a = 3'd1; on_a = 1'b0;
    push_a(pat, 3'd1, 1'b0);
    pulse_a();
    wait_done_a("t6_recovery_done", 2000);
    repeat (5) @(negedge clk);
    check("t6_queue_empty", exp_a_q.size(), 0);

    // 4+5) instance b: 0x83 control byte, [0xC5, byte0], 4-cycle STB gaps,
    // refresh held high gives back-to-back refreshes plus one pending
    seg_b = 8'hA5; bri_b = 3'd3; on_b = 1'b0;
    push_b(); push_b(); push_b();
    base = done_cnt_b;
    @(negedge clk) refresh_b = 1'b1;
    begin
      int n = 0;
      while (done_b !== 1'b1 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("t4_first_done", done_b, 1);
    end
    @(negedge clk);
    check("t4_idle_cycle_busy", busy_b, 0);
    @(negedge clk);
    check("t4_restart_busy", busy_b, 1);
    repeat (10) @(negedge clk);
    refresh_b = 1'b0;
    wait_cnt(1, base + 3, 2000);
    repeat (200) @(negedge clk);
    check("t4_three_refreshes", done_cnt_b - base, 3);
    check("t4_busy_idle", busy_b, 0);
    check("t4_queue_empty", exp_b_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
